// File: rtl/mem_if_pkg.sv
// Shared definitions for the single-port valid/ready memory and its BIST initiator.
// Holds the BIST state encoding, the four test phases and the data pattern helper.
// The pattern helper is width-agnostic: callers truncate its 64-bit result.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  localparam logic [1:0] PH_WR0 = 2'd0;
  localparam logic [1:0] PH_RD0 = 2'd1;
  localparam logic [1:0] PH_WR1 = 2'd2;
  localparam logic [1:0] PH_RD1 = 2'd3;

  // Data written (write phases) or expected (read phases) at one address:
  // addr^seed in the first pass, its complement in the second pass.
  function automatic logic [63:0] bist_pattern(input logic [63:0] addr,
                                               input logic [63:0] seed,
                                               input logic [1:0]  phase);
    logic [63:0] p;
    p = addr ^ seed;
    if (phase == PH_WR1 || phase == PH_RD1) begin
      p = ~p;
    end
    return p;
  endfunction

endpackage

// File: rtl/mem_bist_master.sv
// Memory BIST initiator: write pattern, read/compare, write inverse, read/compare over all addresses.
// Latency: one transaction every 2 cycles, 8*DEPTH cycles per full test; result registered one cycle later.
// Backpressure: waits for m_ready after each 1-cycle m_valid pulse; aborts with timeout after TIMEOUT cycles.
module mem_bist_master
  import mem_if_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      seed,
  output logic                  m_valid,
  output logic                  m_wr_rd,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0]      m_wdata,
  input  logic [WIDTH-1:0]      m_rdata,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  // Wait counter only has to reach TIMEOUT-1.
  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [WAIT_W-1:0]     WAIT_MAX  = WAIT_W'(TIMEOUT - 1);

  bist_state_e           state_q, state_d;
  logic [1:0]            phase_q, phase_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      seed_q, seed_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_wr_rd_q, m_wr_rd_d;
  logic [WIDTH-1:0]      m_wdata_q, m_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic [ADDR_WIDTH+1:0] err_q, err_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;
  logic                  issue;
  logic [WIDTH-1:0]      exp_dat;

  assign exp_dat = WIDTH'(bist_pattern(64'(addr_q), 64'(seed_q), phase_q));

  // Next-state logic: FSM, address/phase stepping, wait timer, compare and result flags.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    addr_d    = addr_q;
    seed_d    = seed_q;
    wait_d    = wait_q;
    m_valid_d = 1'b0;
    m_wr_rd_d = m_wr_rd_q;
    m_wdata_d = m_wdata_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    first_d   = first_q;
    issue     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          seed_d    = seed;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          err_d     = '0;
          first_d   = '0;
          busy_d    = 1'b1;
          addr_d    = '0;
          phase_d   = PH_WR0;
          issue     = 1'b1;
        end
      end
      ISSUE: begin
        // The request cycle itself counts as the first cycle without m_ready.
        wait_d  = WAIT_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (m_ready) begin
          if (phase_q[0] && (m_rdata != exp_dat)) begin
            if (err_q != '1) begin
              err_d = err_q + 1'b1;
            end
            if (err_q == '0) begin
              first_d = addr_q;
            end
          end
          if (addr_q == LAST_ADDR && phase_q == PH_RD1) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_d == '0);
          end else begin
            if (addr_q == LAST_ADDR) begin
              addr_d  = '0;
              phase_d = phase_q + 2'd1;
            end else begin
              addr_d = addr_q + 1'b1;
            end
            issue = 1'b1;
          end
        end else if (wait_q == WAIT_MAX) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue) begin
      state_d   = ISSUE;
      m_valid_d = 1'b1;
      m_wr_rd_d = ~phase_d[0];
      m_wdata_d = phase_d[0] ? '0 : WIDTH'(bist_pattern(64'(addr_d), 64'(seed_d), phase_d));
    end
  end

  // State and output registers; synchronous reset abandons any pending transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= PH_WR0;
      addr_q    <= '0;
      seed_q    <= '0;
      wait_q    <= '0;
      m_valid_q <= 1'b0;
      m_wr_rd_q <= 1'b0;
      m_wdata_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      addr_q    <= addr_d;
      seed_q    <= seed_d;
      wait_q    <= wait_d;
      m_valid_q <= m_valid_d;
      m_wr_rd_q <= m_wr_rd_d;
      m_wdata_q <= m_wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      first_q   <= first_d;
    end
  end

  assign m_valid        = m_valid_q;
  assign m_wr_rd        = m_wr_rd_q;
  assign m_addr         = addr_q;
  assign m_wdata        = m_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule
